// File: rtl/result_pkg.sv
// Shared types and defaults for the result stream reader slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   RESULT_DATA_W / RESULT_ADDR_W : default word width and RAM address width
//   state_t                       : reader FSM encoding
package result_pkg;

  localparam int RESULT_DATA_W = 32;
  localparam int RESULT_ADDR_W = 8;

  // The encoding is fixed because host-side debug reads decode it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/result_ram.sv
// 1R1W result RAM: the adder writes sums, the stream reader reads them back.
// Latency: synchronous read, data valid the cycle after rd_en; read-first on address collision.
// Backpressure: none; rd_data holds its last value while rd_en is low.
//
// Ports:
//   clk              sole clock
//   wr_en/addr/data  write port, accepted every cycle wr_en is high
//   rd_en/rd_addr    read request
//   rd_data          registered read word (not reset)
module result_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Both updates are non-blocking in one process, so a read colliding with a
  // write to the same address returns the word stored before this edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/result_stream_reader.sv
// Streams a window of result-RAM words out over valid/ready; owns the RAM.
// Latency: 2 cycles from start to first out_valid, 1 word per 2 cycles when out_ready stays high.
// Backpressure: out_valid/out_data/out_index hold until out_ready is seen; RAM writes never stall.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data     adder write port into the RAM
//   start, first, count         stream request, sampled only while idle
//   out_valid, out_ready        output handshake
//   out_data, out_index         streamed word and its RAM index
//   busy, done                  not-idle flag, one-cycle completion pulse
//   checksum                    wrapping sum of streamed words, present only
//                               when RESULT_CHECKSUM_EN is defined
module result_stream_reader
  import result_pkg::*;
#(
  parameter int DATA_W = RESULT_DATA_W,
  parameter int ADDR_W = RESULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] first,
  input  logic [ADDR_W:0]   count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // One bit wider than the address so a full-depth window fits.
  logic [ADDR_W:0]   remain_q, remain_d;
  logic              rd_en;
  logic              start_acc;
  logic [DATA_W-1:0] rd_data;

  result_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (addr_q),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    rd_en     = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          if (count == '0) begin
            state_d = DONE;
          end else begin
            addr_d   = first;
            remain_d = count;
            state_d  = FETCH;
          end
        end
      end
      FETCH: begin
        rd_en   = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (remain_q == (ADDR_W+1)'(1)) begin
            state_d = DONE;
          end else begin
            // Natural overflow of the address wraps the window to index 0.
            addr_d   = addr_q + 1'b1;
            remain_d = remain_q - 1'b1;
            state_d  = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The RAM read register only loads in FETCH, so the word presented in SEND
  // stays put through any amount of backpressure, even if the adder rewrites
  // that address meanwhile. Gating with out_valid gives a defined 0 outside
  // SEND since the RAM itself is never reset.
  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? rd_data : '0;
  assign out_index = addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

`ifdef RESULT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (start_acc) begin
      checksum <= '0;
    end else if (out_valid && out_ready) begin
      checksum <= checksum + rd_data;
    end
  end
`endif

endmodule

// File: tb/tb_result_stream_reader.sv
// Self-checking bench for result_stream_reader: shadow-memory reference model,
// table-driven stream requests, random backpressure and hand-written corner cases.
module tb_result_stream_reader;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [AW-1:0] first;
  logic [AW:0]   count;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          busy;
  logic          done;
`ifdef RESULT_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  result_stream_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .first     (first),
    .count     (count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .busy      (busy),
    .done      (done)
`ifdef RESULT_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory: what the RAM should hold after every write the bench made.
  logic [DW-1:0] shadow [DEPTH];

  typedef struct {
    int f;
    int c;
    int mode;      // 0 ready high, 1 random ready, 2 five-cycle stall, 3 start held during stream
    int exp_n;
    int exp_first;
    int exp_last;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d;
    tick();
    wr_en = 1'b0;
    shadow[a] = d;
  endtask

  // Requests a window and consumes it. Expected words come from the shadow
  // memory: word k of the window is shadow[(f+k) mod DEPTH].
  task automatic run_stream(input int f, input int c, input int mode,
                            output int n_got, output int idx_first,
                            output int idx_last, output int cycles);
    logic [DW-1:0] exp_d[$];
    int            exp_i[$];
    logic [DW-1:0] sum;
    logic [DW-1:0] prev_d;
    logic [AW-1:0] prev_i;
    bit            done_due, prev_stall, finished;
    int            low_left;
    bit            r;
    sum = '0;
    for (int k = 0; k < c; k++) begin
      exp_i.push_back((f + k) % DEPTH);
      exp_d.push_back(shadow[(f + k) % DEPTH]);
    end
    n_got = 0; idx_first = -1; idx_last = -1; cycles = 0;
    check("idle_before_start", busy, 0);
    start = 1'b1;
    first = f[AW-1:0];
    count = c[AW:0];
    tick();
    if (mode == 3) begin
      // Keep start asserted with a different window; it must be ignored.
      first = first + 8'd37;
      count = 9'd5;
    end else begin
      start = 1'b0;
    end
`ifdef RESULT_CHECKSUM_EN
    check("cksum_clear_on_start", checksum, 0);
`endif
    done_due = (c == 0);
    prev_stall = 1'b0;
    finished = 1'b0;
    prev_d = '0;
    prev_i = '0;
    low_left = (mode == 2) ? 5 : 0;
    while (!finished && cycles < 20 * c + 40) begin
      case (mode)
        1: r = ($urandom_range(0, 2) != 0);
        2: begin
          if (out_valid && low_left > 0) begin
            r = 1'b0;
            low_left--;
          end else begin
            r = 1'b1;
          end
        end
        default: r = 1'b1;
      endcase
      out_ready = r;
      check("done_pulse", done, done_due);
      if (done_due) begin
        check("valid_in_done", out_valid, 0);
`ifdef RESULT_CHECKSUM_EN
        check("cksum_at_done", checksum, sum);
`endif
        finished = 1'b1;
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_d);
        check("stall_index", out_index, prev_i);
      end
      done_due = 1'b0;
      if (!finished && out_valid && out_ready) begin
        if (exp_d.size() == 0) begin
          check("extra_word", n_got + 1, c);
        end else begin
          check("word_data", out_data, exp_d.pop_front());
          check("word_index", out_index, exp_i.pop_front());
        end
        sum = sum + out_data;
        if (n_got == 0) idx_first = out_index;
        idx_last = out_index;
        n_got++;
        if (n_got == c) done_due = 1'b1;
        prev_stall = 1'b0;
      end else begin
        prev_stall = out_valid;
      end
      prev_d = out_data;
      prev_i = out_index;
      if (!finished) begin
        tick();
        cycles++;
      end
    end
    start = 1'b0;
    if (!finished) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stream_timeout: first=%0d count=%0d got %0d words, no done within %0d cycles",
               f, c, n_got, cycles);
    end
    tick();
    check("idle_after_done", busy, 0);
    check("no_second_done", done, 0);
`ifdef RESULT_CHECKSUM_EN
    check("cksum_stable", checksum, sum);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    int n, fi, la, cy;
    bit seen;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; first = '0; count = '0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
`ifdef RESULT_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif
    rst = 1'b0;
    tick();

    for (int i = 0; i < DEPTH; i++) wr(i, $urandom);

    // Basic stream of known values with ready held high.
    wr(0, 5); wr(1, 7); wr(2, 9); wr(3, 11);
    run_stream(0, 4, 0, n, fi, la, cy);
    check("t1_words", n, 4);
    check("t1_first", fi, 0);
    check("t1_last", la, 3);
    check("t1_cycles", cy, 8);
`ifdef RESULT_CHECKSUM_EN
    check("t1_checksum", checksum, 32);
`endif

    // Window crossing the top of the RAM.
    for (int i = 252; i < 256; i++) wr(i, $urandom);
    wr(0, $urandom); wr(1, $urandom);
    run_stream(254, 4, 0, n, fi, la, cy);
    check("t2_words", n, 4);
    check("t2_first", fi, 254);
    check("t2_last", la, 1);

    tbl = '{
      '{0,   4,   0, 4,   0,   3},
      '{254, 4,   1, 4,   254, 1},
      '{10,  3,   2, 3,   10,  12},
      '{0,   0,   0, 0,   -1,  -1},
      '{50,  6,   3, 6,   50,  55},
      '{0,   256, 0, 256, 0,   255},
      '{200, 100, 1, 100, 200, 43},
      '{255, 1,   2, 1,   255, 255}
    };
    for (int i = 0; i < 8; i++) begin
      run_stream(tbl[i].f, tbl[i].c, tbl[i].mode, n, fi, la, cy);
      check("tbl_words", n, tbl[i].exp_n);
      check("tbl_first", fi, tbl[i].exp_first);
      check("tbl_last", la, tbl[i].exp_last);
      if (tbl[i].mode == 0) check("tbl_cycles", cy, 2 * tbl[i].c);
    end

    for (int i = 0; i < 6; i++) begin
      int rf, rc;
      rf = $urandom_range(0, DEPTH - 1);
      rc = $urandom_range(0, 40);
      run_stream(rf, rc, 1, n, fi, la, cy);
      check("rand_words", n, rc);
    end

    // Reset while a word is being offered.
    start = 1'b1; first = '0; count = 9'd4;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    check("t5_reached_send", seen, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_index", out_index, 0);
    check("t5_data", out_data, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_done", done, 0);
      check("t5_stay_idle", busy, 0);
    end
    run_stream(0, 4, 1, n, fi, la, cy);
    check("t5_words_after_rst", n, 4);

`ifdef RESULT_CHECKSUM_EN
    wr(100, 32'hFFFF_FFFF); wr(101, 32'hFFFF_FFFF);
    run_stream(100, 2, 0, n, fi, la, cy);
    check("t6_cksum_wrap", checksum, 32'hFFFF_FFFE);
    run_stream(0, 0, 0, n, fi, la, cy);
    check("t6_cksum_cleared", checksum, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
